pcpi_copro_arbiter: RTL and testbench
=====================================

// Module: pcpi_copro_arbiter
// PURPOSE
//  Shares the core's single PCPI port among NUM_COP coprocessors (pcpi_mul, pcpi_galois, ...).
//  - Broadcasts each request and grants it to the first coprocessor that claims it.
//  - Returns that coprocessor's result to the core.
//  - A watchdog ends a stalled, granted operation.
//  Sits between the picorv32 PCPI master and the coprocessor instances; adds one registered stage each way.
// PARAMETERS
//  NUM_COP   2    number of coprocessor slots; index 0 has highest claim priority
//  TIMEOUT   64   max cycles in OWNED before the watchdog forces a response (>=2)
//  TW        $clog2(TIMEOUT+1)  watchdog counter width (derived, do not override)
// PORTS
//  clk         in   1           clock, all logic on rising edge
//  reset       in   1           synchronous, active-high reset
//  pcpi_valid  in   1           core request valid (held until pcpi_ready or core abort)
//  pcpi_insn   in   32          instruction word
//  pcpi_rs1    in   32          operand 1
//  pcpi_rs2    in   32          operand 2
//  pcpi_wr     out  1           result writes rd (valid with pcpi_ready)
//  pcpi_rd     out  32          result data (valid with pcpi_ready)
//  pcpi_wait   out  1           request claimed, core must not trap
//  pcpi_ready  out  1           one-cycle completion pulse
//  cop_valid   out  NUM_COP     per-coprocessor request valid
//  cop_insn    out  32          registered copy of pcpi_insn, shared by all slots
//  cop_rs1     out  32          registered operand 1, shared
//  cop_rs2     out  32          registered operand 2, shared
//  cop_wr      in   NUM_COP     per-slot write flag
//  cop_rd      in   32*NUM_COP  per-slot result; slot i at [32*i+31:32*i]
//  cop_wait    in   NUM_COP     per-slot claim/busy
//  cop_ready   in   NUM_COP     per-slot completion
//  busy        out  1           state != IDLE
//  tmo_err     out  1           one-cycle pulse when the watchdog fires
// BEHAVIOUR
//  Reset: state=IDLE, grant=0, wdog=0. All outputs are 0, including cop_* data registers.
//  Reset wins over every other event, including mid-operation; coprocessors see cop_valid=0 next cycle.
//  IDLE:   pcpi_valid=1 -> latch insn/rs1/rs2 into cop_*; cop_valid<=all ones; go CLAIM.
//  CLAIM:  c = cop_wait|cop_ready. If c!=0, grant = lowest set index of c.
//          - cop_ready[grant]=1 -> capture that slot's rd/wr, go DONE.
//          - Otherwise cop_valid<=onehot(grant), pcpi_wait<=1, wdog<=0, go OWNED.
//          If c==0, stay; no pcpi_wait. The core's own claim timeout applies.
//  OWNED:  cop_valid=onehot(grant); pcpi_wait=1; wdog increments every cycle.
//          - cop_ready[grant] -> capture cop_rd[grant], cop_wr[grant]; go DONE.
//          - cop_wait/cop_ready from non-granted slots are ignored.
//          - wdog==TIMEOUT-1 with no ready -> tmo_err=1 for 1 cycle; go DONE with wr=0, rd=0.
//  DONE:   pcpi_ready=1 for exactly one cycle with captured pcpi_wr/pcpi_rd.
//          cop_valid=0 and pcpi_wait=0 in DONE; go FLUSH.
//  FLUSH:  wait for pcpi_valid=0, then IDLE. Guarantees a new request is never mistaken for the old one.
//  Abort:  pcpi_valid=0 observed in CLAIM or OWNED -> cop_valid<=0, pcpi_wait<=0, go IDLE.
//          No pcpi_ready and no tmo_err are produced.
//  Latency: sample pcpi_valid at edge N -> cop_valid high after N. Sample cop_ready at edge M -> pcpi_ready high after M.
//  pcpi_rd/pcpi_wr hold their value outside DONE; consumers only read them with pcpi_ready.
//  Watchdog saturates and clears on every entry to OWNED.
// TESTING
//  1 GF op: valid, insn=0x0820A1B3 (CLMUL class). Slot1 wait at cycle+1, ready 3 cycles later, rd=0x12, wr=1
//    -> cop_valid 11 then 10; pcpi_wait=1; one pcpi_ready, rd=0x12, wr=1.
//  2 Claim race: slots 0 and 1 both assert wait in the same CLAIM cycle
//    -> grant 0, cop_valid=01; later slot1 ready (rd=0xDEAD) is ignored; slot0 ready rd=0x3A097A is returned.
//  3 Instant ready: slot0 asserts ready (no wait) in CLAIM with rd=0x5, wr=1
//    -> DONE directly; pcpi_ready 1 cycle, rd=0x5; pcpi_wait never high.
//  4 No claimant: valid held 16 cycles, then dropped
//    -> pcpi_wait, pcpi_ready and tmo_err all stay 0; busy falls 1 cycle after the drop.
//  5 Watchdog, TIMEOUT=64: slot1 holds wait, never ready
//    -> after 64 OWNED cycles tmo_err pulses; pcpi_ready=1 with wr=0, rd=0; then FLUSH and IDLE.
//  6 Abort/reset: pcpi_valid drops in OWNED -> cop_valid=00 next cycle, no pcpi_ready.
//    Repeat with reset=1 in OWNED -> all outputs 0 next cycle, state IDLE.

Source files
------------

// File: rtl/pcpi_copro_arbiter.sv
// pcpi_copro_arbiter: shares one PCPI port among NUM_COP coprocessors, first claimant wins,
// with a registered stage each way and a watchdog on granted operations.
module pcpi_copro_arbiter #(
    parameter int NUM_COP = 2,
    parameter int TIMEOUT = 64,
    localparam int TW = $clog2(TIMEOUT + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pcpi_valid,
    input  logic [31:0]            pcpi_insn,
    input  logic [31:0]            pcpi_rs1,
    input  logic [31:0]            pcpi_rs2,
    output logic                   pcpi_wr,
    output logic [31:0]            pcpi_rd,
    output logic                   pcpi_wait,
    output logic                   pcpi_ready,
    output logic [NUM_COP-1:0]     cop_valid,
    output logic [31:0]            cop_insn,
    output logic [31:0]            cop_rs1,
    output logic [31:0]            cop_rs2,
    input  logic [NUM_COP-1:0]     cop_wr,
    input  logic [32*NUM_COP-1:0]  cop_rd,
    input  logic [NUM_COP-1:0]     cop_wait,
    input  logic [NUM_COP-1:0]     cop_ready,
    output logic                   busy,
    output logic                   tmo_err
);
    localparam int GW = (NUM_COP > 1) ? $clog2(NUM_COP) : 1;
    typedef enum logic [2:0] {IDLE, CLAIM, OWNED, DONE, FLUSH} state_t;
    state_t        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d, claim_idx, sel;
    logic [TW-1:0] wdog_q, wdog_d;
    logic [31:0]   insn_q, insn_d, rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d, sel_rd;
    logic          wr_q, wr_d, tmo_q, tmo_d, sel_wr, sel_rdy;
    logic [NUM_COP-1:0] claim;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            wdog_q  <= '0;
            insn_q  <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            wr_q    <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            wdog_q  <= wdog_d;
            insn_q  <= insn_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            tmo_q   <= tmo_d;
        end
    end
    // Lowest claiming index wins; in OWNED only the granted slot is ever looked at.
    always_comb begin
        claim     = cop_wait | cop_ready;
        claim_idx = '0;
        for (int i = NUM_COP - 1; i >= 0; i--)
            if (claim[i]) claim_idx = GW'(i);
        sel     = (state_q == CLAIM) ? claim_idx : grant_q;
        sel_rd  = cop_rd[32*int'(sel) +: 32];
        sel_wr  = cop_wr[sel];
        sel_rdy = cop_ready[sel];
    end
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        wdog_d  = wdog_q;
        insn_d  = insn_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        tmo_d   = 1'b0;
        case (state_q)
            IDLE: if (pcpi_valid) begin
                insn_d  = pcpi_insn;
                rs1_d   = pcpi_rs1;
                rs2_d   = pcpi_rs2;
                state_d = CLAIM;
            end
            CLAIM: if (!pcpi_valid) state_d = IDLE;
            else if (claim != '0) begin
                grant_d = claim_idx;
                wdog_d  = '0;
                state_d = sel_rdy ? DONE : OWNED;
                rd_d    = sel_rdy ? sel_rd : rd_q;
                wr_d    = sel_rdy ? sel_wr : wr_q;
            end
            OWNED: if (!pcpi_valid) state_d = IDLE;
            else if (sel_rdy) begin
                rd_d    = sel_rd;
                wr_d    = sel_wr;
                state_d = DONE;
            end else if (wdog_q == TW'(TIMEOUT - 1)) begin
                rd_d    = '0;
                wr_d    = 1'b0;
                tmo_d   = 1'b1;
                state_d = DONE;
            end else wdog_d = wdog_q + 1'b1;
            DONE:    state_d = FLUSH;
            FLUSH:   state_d = pcpi_valid ? FLUSH : IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        busy       = state_q != IDLE;
        pcpi_wait  = state_q == OWNED;
        pcpi_ready = state_q == DONE;
        tmo_err    = tmo_q;
        pcpi_rd    = rd_q;
        pcpi_wr    = wr_q;
        cop_insn   = insn_q;
        cop_rs1    = rs1_q;
        cop_rs2    = rs2_q;
        cop_valid  = (state_q == CLAIM) ? '1 : (state_q == OWNED) ? NUM_COP'(1) << grant_q : '0;
    end
endmodule

// File: tb/tb_pcpi_copro_arbiter.sv
// tb_pcpi_copro_arbiter: directed vectors; completions checked by a scoreboard monitor.
module tb_pcpi_copro_arbiter;
    logic        clk = 0, reset = 1;
    logic        pcpi_valid = 0;
    logic [31:0] pcpi_insn = 0, pcpi_rs1 = 0, pcpi_rs2 = 0;
    logic        pcpi_wr, pcpi_wait, pcpi_ready, busy, tmo_err;
    logic [31:0] pcpi_rd, cop_insn, cop_rs1, cop_rs2;
    logic [1:0]  cop_valid;
    logic [1:0]  cop_wr = 0, cop_wait = 0, cop_ready = 0;
    logic [63:0] cop_rd = 0;
    int tests = 0, fails = 0;
    bit done = 0;

    typedef struct { logic [31:0] rd; logic wr; logic tmo; } exp_t;
    exp_t sb[$];

    pcpi_copro_arbiter dut (
        .clk(clk), .reset(reset), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
        .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
        .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready), .cop_valid(cop_valid),
        .cop_insn(cop_insn), .cop_rs1(cop_rs1), .cop_rs2(cop_rs2), .cop_wr(cop_wr),
        .cop_rd(cop_rd), .cop_wait(cop_wait), .cop_ready(cop_ready), .busy(busy), .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_done(input logic [31:0] rd, input logic wr, input logic tmo);
        exp_t e;
        e.rd = rd; e.wr = wr; e.tmo = tmo;
        sb.push_back(e);
    endtask

    task automatic start(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
        pcpi_valid = 1; pcpi_insn = insn; pcpi_rs1 = a; pcpi_rs2 = b;
        tick();
    endtask

    task automatic finish_op();
        cop_wait = 0; cop_ready = 0; pcpi_valid = 0;
        tick(2);
        check("idle_after_flush", busy, 0);
    endtask

    // Monitor: every completion pulse pops one expected response.
    initial begin
        exp_t e;
        while (!done) begin
            @(negedge clk);
            if (reset) continue;
            if (pcpi_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_ready", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("rd", pcpi_rd, e.rd);
                    check("wr", pcpi_wr, e.wr);
                    check("tmo_err", tmo_err, e.tmo);
                end
            end else if (tmo_err) begin
                check("tmo_without_ready", tmo_err, 0);
            end
        end
    end

    initial begin
        tick(2);
        check("rst_busy", busy, 0);
        check("rst_cop_valid", cop_valid, 0);
        check("rst_ready_wait", {pcpi_ready, pcpi_wait, tmo_err}, 0);
        reset = 0;

        // 1: GF op on slot 1
        start(32'h0820A1B3, 32'h7, 32'h9);
        check("t1_cop_valid_claim", cop_valid, 2'b11);
        check("t1_cop_insn", cop_insn, 32'h0820A1B3);
        check("t1_cop_rs1", cop_rs1, 32'h7);
        check("t1_wait_claim", pcpi_wait, 0);
        cop_wait = 2'b10;
        tick();
        check("t1_cop_valid_owned", cop_valid, 2'b10);
        check("t1_wait_owned", pcpi_wait, 1);
        tick(2);
        cop_ready = 2'b10; cop_rd = {32'h12, 32'hFFFF}; cop_wr = 2'b10;
        expect_done(32'h12, 1, 0);
        tick();
        check("t1_ready", pcpi_ready, 1);
        check("t1_done_valid_wait", {cop_valid, pcpi_wait}, 0);
        finish_op();

        // 2: claim race, slot 0 wins, slot 1 ready ignored
        start(32'h0000_0033, 1, 2);
        cop_wait = 2'b11;
        tick();
        check("t2_cop_valid", cop_valid, 2'b01);
        cop_ready = 2'b10; cop_rd = {32'hDEAD, 32'h0}; cop_wr = 2'b10;
        tick();
        check("t2_still_owned", {pcpi_wait, pcpi_ready}, 2'b10);
        cop_ready = 2'b01; cop_rd = {32'hDEAD, 32'h3A097A}; cop_wr = 2'b01;
        expect_done(32'h3A097A, 1, 0);
        tick();
        check("t2_ready", pcpi_ready, 1);
        finish_op();

        // 3: instant ready in CLAIM
        start(32'h0200_0033, 3, 4);
        cop_ready = 2'b01; cop_rd = {32'h0, 32'h5}; cop_wr = 2'b01;
        expect_done(32'h5, 1, 0);
        tick();
        check("t3_ready_no_wait", {pcpi_ready, pcpi_wait}, 2'b10);
        finish_op();

        // 4: no claimant for 16 cycles, then abort
        start(32'h1234_5678, 0, 0);
        for (int i = 0; i < 15; i++) begin
            tick();
            check("t4_wait_low", pcpi_wait, 0);
        end
        check("t4_busy_held", busy, 1);
        pcpi_valid = 0;
        tick();
        check("t4_busy_fall", busy, 0);

        // 5: watchdog after 64 OWNED cycles
        start(32'h0820A1B3, 5, 6);
        cop_wait = 2'b10; cop_rd = {32'hBEEF, 32'h0}; cop_wr = 2'b10;
        tick();
        expect_done(0, 0, 1);
        tick(63);
        check("t5_owned_at_63", {pcpi_wait, pcpi_ready, tmo_err}, 3'b100);
        tick();
        check("t5_timeout", {pcpi_ready, tmo_err, pcpi_wr}, 3'b110);
        check("t5_rd_zero", pcpi_rd, 0);
        finish_op();

        // 6a: abort in OWNED
        start(32'hAAAA_5555, 8, 9);
        cop_wait = 2'b01;
        tick();
        check("t6_owned", pcpi_wait, 1);
        pcpi_valid = 0;
        tick();
        check("t6_abort", {cop_valid, pcpi_wait, busy}, 0);
        cop_wait = 0;
        tick();

        // 6b: reset in OWNED
        start(32'h5555_AAAA, 32'h11, 32'h22);
        cop_wait = 2'b10;
        tick();
        check("t6b_owned", cop_valid, 2'b10);
        reset = 1;
        tick();
        check("t6b_rst_ctl", {cop_valid, pcpi_wait, pcpi_ready, busy, tmo_err}, 0);
        check("t6b_rst_data", {cop_insn, cop_rs1}, 0);
        check("t6b_rst_rs2_rd", {cop_rs2, pcpi_rd, 31'b0, pcpi_wr}, 0);
        reset = 0; pcpi_valid = 0; cop_wait = 0;
        tick(3);

        check("sb_empty", sb.size(), 0);
        done = 1;
        tick(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
